// File: rtl/bin_clock_ctrl.sv
// bin_clock_ctrl: front-end controller for the binary clock time core.
//   - 1 Hz time-base tick with hold (freeze) and deferral around adjust pulses
//   - 2-flop synchroniser and per-bit debounce for the six set buttons
//   - single-owner arbitration (hour > min > sec) of the adjust path
//   - one-cycle adjust pulses with hold-to-repeat
//
// Optional feature macro: BIN_CLOCK_ACCEL_EN
//   defined   : after 8 consecutive repeat pulses the repeat interval shrinks
//               to REPEAT_CYCLES/4 (minimum 1)
//   undefined : repeat interval is always REPEAT_CYCLES
//
// Ports:
//   clk_i        system clock
//   rstn_i       asynchronous active-low reset
//   btn_i[5:0]   raw buttons {hour_inc, hour_dec, min_inc, min_dec, sec_inc, sec_dec}
//   hold_i       freeze the time base (synchronous level)
//   tick_o       one-cycle pulse: advance time by one second
//   adj_field_o  field of the current adjust pulse (0 none, 1 sec, 2 min, 3 hour)
//   adj_up_o     one-cycle increment pulse
//   adj_dn_o     one-cycle decrement pulse
//   busy_o       high while a button owns the adjust path
module bin_clock_ctrl #(
  parameter int unsigned TICK_DIV      = 10_000_000,
  parameter int unsigned DB_CYCLES     = 200_000,
  parameter int unsigned HOLD_CYCLES   = 5_000_000,
  parameter int unsigned REPEAT_CYCLES = 1_000_000
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [5:0] btn_i,
  input  logic       hold_i,
  output logic       tick_o,
  output logic [1:0] adj_field_o,
  output logic       adj_up_o,
  output logic       adj_dn_o,
  output logic       busy_o
);

  localparam int unsigned NBTN      = 6;
  localparam int unsigned TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TICK_LAST = (TICK_DIV > 0) ? TICK_DIV - 1 : 0;
  localparam int unsigned DB_W      = $clog2(DB_CYCLES + 1);
  localparam int unsigned DB_LAST   = (DB_CYCLES > 0) ? DB_CYCLES - 1 : 0;
  localparam int unsigned IVL_MAX   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned IVL_W     = $clog2(IVL_MAX + 1);
  localparam int unsigned EL_W      = IVL_W + 1;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_SEC  = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_HOUR = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FIRE    = 3'd1,
    S_WAIT    = 3'd2,
    S_FIRE_R  = 3'd3,
    S_RPT     = 3'd4,
    S_RELEASE = 3'd5
  } state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // Button synchroniser (2 flops per bit)
  // ---------------------------------------------------------------------------
  logic [NBTN-1:0] sync_q1, sync_q2;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_i;
      sync_q2 <= sync_q1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: level flips after DB_CYCLES consecutive differing samples
  // ---------------------------------------------------------------------------
  logic [NBTN-1:0] db_q;
  logic [DB_W-1:0] db_cnt_q [NBTN];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      db_q <= '0;
      for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (sync_q2[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_W'(DB_LAST)) begin
          db_q[i]     <= sync_q2[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request decode and fixed-priority arbitration (hour > min > sec)
  // A field requests only when exactly one of its inc/dec is pressed.
  // ---------------------------------------------------------------------------
  logic            hour_req_c, min_req_c, sec_req_c;
  logic            arb_valid_c;
  logic [1:0]      arb_field_c;
  logic            arb_up_c;
  logic [NBTN-1:0] arb_mask_c;

  assign hour_req_c = db_q[5] ^ db_q[4];
  assign min_req_c  = db_q[3] ^ db_q[2];
  assign sec_req_c  = db_q[1] ^ db_q[0];

  always_comb begin
    arb_valid_c = 1'b0;
    arb_field_c = FLD_NONE;
    arb_up_c    = 1'b0;
    arb_mask_c  = '0;
    if (hour_req_c) begin
      arb_valid_c = 1'b1;
      arb_field_c = FLD_HOUR;
      arb_up_c    = db_q[5];
      arb_mask_c  = db_q[5] ? 6'b10_0000 : 6'b01_0000;
    end else if (min_req_c) begin
      arb_valid_c = 1'b1;
      arb_field_c = FLD_MIN;
      arb_up_c    = db_q[3];
      arb_mask_c  = db_q[3] ? 6'b00_1000 : 6'b00_0100;
    end else if (sec_req_c) begin
      arb_valid_c = 1'b1;
      arb_field_c = FLD_SEC;
      arb_up_c    = db_q[1];
      arb_mask_c  = db_q[1] ? 6'b00_0010 : 6'b00_0001;
    end
  end

  // Owner is latched only on the IDLE -> FIRE transition
  logic [1:0]      owner_field_q;
  logic            owner_up_q;
  logic [NBTN-1:0] owner_mask_q;
  logic            owner_held_c;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      owner_field_q <= FLD_NONE;
      owner_up_q    <= 1'b0;
      owner_mask_q  <= '0;
    end else if (state_q == S_IDLE && arb_valid_c) begin
      owner_field_q <= arb_field_c;
      owner_up_q    <= arb_up_c;
      owner_mask_q  <= arb_mask_c;
    end
  end

  assign owner_held_c = |(db_q & owner_mask_q);

  // ---------------------------------------------------------------------------
  // Interval counter. The pulse cycle itself is interval cycle 0, so the
  // next pulse state is entered when elapsed cycles reach interval-1.
  // ---------------------------------------------------------------------------
  logic [IVL_W-1:0] ivl_cnt_q;
  logic [EL_W-1:0]  ivl_elapsed_c;
  logic [EL_W-1:0]  rpt_ivl_c;
  logic             wait_done_c, rpt_done_c;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ivl_cnt_q <= '0;
    end else if (state_q == S_FIRE || state_q == S_FIRE_R) begin
      ivl_cnt_q <= '0;
    end else if (state_q == S_WAIT || state_q == S_RPT) begin
      ivl_cnt_q <= ivl_cnt_q + IVL_W'(1);
    end
  end

`ifdef BIN_CLOCK_ACCEL_EN
  localparam int unsigned FAST_IVL = (REPEAT_CYCLES / 4 < 1) ? 1 : REPEAT_CYCLES / 4;

  // Consecutive repeat pulses since the first press, saturating at 8
  logic [3:0] rpt_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rpt_cnt_q <= '0;
    end else if (state_q == S_FIRE) begin
      rpt_cnt_q <= '0;
    end else if (state_q == S_FIRE_R && rpt_cnt_q != 4'd8) begin
      rpt_cnt_q <= rpt_cnt_q + 4'd1;
    end
  end

  assign rpt_ivl_c = (rpt_cnt_q == 4'd8) ? EL_W'(FAST_IVL) : EL_W'(REPEAT_CYCLES);
`else
  assign rpt_ivl_c = EL_W'(REPEAT_CYCLES);
`endif

  assign ivl_elapsed_c = EL_W'(ivl_cnt_q) + EL_W'(1);
  assign wait_done_c   = (ivl_elapsed_c >= EL_W'(HOLD_CYCLES - 1));
  assign rpt_done_c    = (ivl_elapsed_c >= (rpt_ivl_c - EL_W'(1)));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next-state logic (release wins over interval expiry)
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (arb_valid_c) state_d = S_FIRE;
      S_FIRE:    state_d = S_WAIT;
      S_WAIT: begin
        if (!owner_held_c)    state_d = S_RELEASE;
        else if (wait_done_c) state_d = S_FIRE_R;
      end
      S_FIRE_R:  state_d = S_RPT;
      S_RPT: begin
        if (!owner_held_c)   state_d = S_RELEASE;
        else if (rpt_done_c) state_d = S_FIRE_R;
      end
      S_RELEASE: if (db_q == '0) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM: output decode (registered below)
  logic       pulse_c;
  logic [1:0] field_c;
  logic       up_c, dn_c, busy_c;

  always_comb begin
    pulse_c = 1'b0;
    field_c = FLD_NONE;
    up_c    = 1'b0;
    dn_c    = 1'b0;
    busy_c  = (state_d != S_IDLE);
    if (state_q == S_FIRE || state_q == S_FIRE_R) begin
      pulse_c = 1'b1;
      field_c = owner_field_q;
      up_c    = owner_up_q;
      dn_c    = ~owner_up_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Time base. A tick colliding with an adjust pulse is deferred via a
  // pending flag; the counter phase is never disturbed by the deferral.
  // ---------------------------------------------------------------------------
  logic [TICK_W-1:0] tb_cnt_q;
  logic              tb_last_c, tick_req_c, tick_c, tick_pend_q;

  assign tb_last_c  = (tb_cnt_q == TICK_W'(TICK_LAST));
  assign tick_req_c = ~hold_i & tb_last_c;
  assign tick_c     = (tick_req_c | tick_pend_q) & ~pulse_c;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tb_cnt_q    <= '0;
      tick_pend_q <= 1'b0;
    end else begin
      if (!hold_i) tb_cnt_q <= tb_last_c ? '0 : tb_cnt_q + TICK_W'(1);
      tick_pend_q <= (tick_req_c | tick_pend_q) & pulse_c;
    end
  end

  // Output registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tick_o      <= 1'b0;
      adj_field_o <= FLD_NONE;
      adj_up_o    <= 1'b0;
      adj_dn_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      tick_o      <= tick_c;
      adj_field_o <= field_c;
      adj_up_o    <= up_c;
      adj_dn_o    <= dn_c;
      busy_o      <= busy_c;
    end
  end

endmodule

// File: tb/tb_bin_clock_ctrl.sv
// tb_bin_clock_ctrl: directed self-checking bench for bin_clock_ctrl with
// TICK_DIV=10, DB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5.
// Cycle numbers are counted from the clock edge right after reset release;
// inputs change 1 time unit after an edge, outputs are sampled there too.
// Debounce latency 6 edges, +1 edge to FIRE, +1 edge for the output register:
// a press driven after edge k yields its first pulse at cycle k+8.
module tb_bin_clock_ctrl;

  logic       clk;
  logic       rstn;
  logic [5:0] btn;
  logic       hold;
  logic       tick_o;
  logic [1:0] adj_field_o;
  logic       adj_up_o;
  logic       adj_dn_o;
  logic       busy_o;

  bin_clock_ctrl #(
    .TICK_DIV      (10),
    .DB_CYCLES     (4),
    .HOLD_CYCLES   (20),
    .REPEAT_CYCLES (5)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .btn_i       (btn),
    .hold_i      (hold),
    .tick_o      (tick_o),
    .adj_field_o (adj_field_o),
    .adj_up_o    (adj_up_o),
    .adj_dn_o    (adj_dn_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int viol     = 0;
  int busy_cnt = 0;
  int p_cyc [$];
  int p_fld [$];
  int p_up  [$];
  int t_cyc [$];
  logic busy_hist [0:127];

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag, input int q[$], input int e[$]);
    check({tag, "_count"}, q.size(), e.size());
    foreach (e[i]) check($sformatf("%s_%0d", tag, i), (i < q.size()) ? q[i] : -1, e[i]);
  endtask

  // Advance one cycle and record pulses, ticks, busy and output-rule violations
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (adj_up_o || adj_dn_o) begin
      p_cyc.push_back(cyc);
      p_fld.push_back(int'(adj_field_o));
      p_up.push_back(int'(adj_up_o));
    end
    if (tick_o) t_cyc.push_back(cyc);
    if ((adj_up_o && adj_dn_o) ||
        ((adj_up_o || adj_dn_o) != (adj_field_o != 2'd0)) ||
        (tick_o && (adj_up_o || adj_dn_o))) viol++;
    if (busy_o) busy_cnt++;
    if (cyc < 128) busy_hist[cyc] = busy_o;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input string tag);
    btn  = '0;
    hold = 1'b0;
    rstn = 1'b0;
    #1;
    check({tag, "_rst_outs"}, {tick_o, adj_field_o, adj_up_o, adj_dn_o, busy_o}, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc      = 0;
    viol     = 0;
    busy_cnt = 0;
    p_cyc.delete();
    p_fld.delete();
    p_up.delete();
    t_cyc.delete();
    for (int i = 0; i < 128; i++) busy_hist[i] = 1'b0;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_q [$];
    btn  = '0;
    hold = 1'b0;
    rstn = 1'b0;

    // 1: idle time base, tick every 10 cycles
    do_reset("t1");
    for (int i = 0; i < 40; i++) begin
      step();
      check($sformatf("t1_tick_c%0d", cyc), tick_o, (cyc % 10 == 0) ? 1 : 0);
    end
    check("t1_no_pulse", p_cyc.size(), 0);
    check("t1_busy", busy_cnt, 0);
    check("t1_viol", viol, 0);

    // 2: bounced min_inc, single up pulse on field 2
    do_reset("t2");
    for (int i = 0; i < 10; i++) begin
      btn[3] = ((i / 2) % 2 == 1);
      step();
    end
    check("t2_no_pulse_bounce", p_cyc.size(), 0);
    btn[3] = 1'b1;
    steps(8);
    btn[3] = 1'b0;
    steps(22);
    exp_q = '{18};
    check_q("t2_pulse_cyc", p_cyc, exp_q);
    exp_q = '{2};
    check_q("t2_pulse_fld", p_fld, exp_q);
    exp_q = '{1};
    check_q("t2_pulse_up", p_up, exp_q);
    check("t2_busy16", busy_hist[16], 0);
    check("t2_busy17", busy_hist[17], 1);
    check("t2_busy25", busy_hist[25], 1);
    check("t2_busy26", busy_hist[26], 0);
    check("t2_viol", viol, 0);

    // 3: hour_dec held -> first pulse, repeat after 20, then every 5
    do_reset("t3");
    btn[4] = 1'b1;
    steps(59);
    btn[4] = 1'b0;
    steps(21);
    exp_q = '{8, 28, 33, 38, 43, 48, 53, 58, 63};
    check_q("t3_pulse_cyc", p_cyc, exp_q);
    exp_q = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
    check_q("t3_pulse_fld", p_fld, exp_q);
    exp_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_q("t3_pulse_up", p_up, exp_q);
    exp_q = '{10, 20, 30, 40, 50, 60, 70, 80};
    check_q("t3_tick", t_cyc, exp_q);
    check("t3_busy6", busy_hist[6], 0);
    check("t3_busy7", busy_hist[7], 1);
    check("t3_busy66", busy_hist[66], 1);
    check("t3_busy67", busy_hist[67], 0);
    check("t3_viol", viol, 0);

    // 4: sec_inc + hour_inc together -> hour wins, no re-arbitration mid-press
    do_reset("t4");
    btn[5] = 1'b1;
    btn[1] = 1'b1;
    steps(10);
    btn[5] = 1'b0;
    steps(20);
    btn[1] = 1'b0;
    steps(10);
    btn[1] = 1'b1;
    steps(10);
    btn[1] = 1'b0;
    steps(20);
    exp_q = '{8, 48};
    check_q("t4_pulse_cyc", p_cyc, exp_q);
    exp_q = '{3, 1};
    check_q("t4_pulse_fld", p_fld, exp_q);
    exp_q = '{1, 1};
    check_q("t4_pulse_up", p_up, exp_q);
    check("t4_busy30", busy_hist[30], 1);
    check("t4_busy36", busy_hist[36], 1);
    check("t4_busy37", busy_hist[37], 0);
    check("t4_busy48", busy_hist[48], 1);
    check("t4_viol", viol, 0);

    // 5: min_inc + min_dec -> no request; hold_i over a terminal count
    do_reset("t5");
    btn[3] = 1'b1;
    btn[2] = 1'b1;
    steps(19);
    hold = 1'b1;
    steps(30);
    hold = 1'b0;
    steps(26);
    btn = '0;
    exp_q = '{10, 50, 60, 70};
    check_q("t5_tick", t_cyc, exp_q);
    check("t5_no_pulse", p_cyc.size(), 0);
    check("t5_busy", busy_cnt, 0);
    check("t5_viol", viol, 0);

    // 6: pulses aligned to tick terminal counts, then reset mid-RPT
    do_reset("t6");
    steps(12);
    btn[0] = 1'b1;
    steps(38);
    check("t6_busy_before_rst", busy_o, 1);
    check("t6_dn_before_rst", adj_dn_o, 1);
    exp_q = '{20, 40, 45, 50};
    check_q("t6_pulse_cyc", p_cyc, exp_q);
    exp_q = '{1, 1, 1, 1};
    check_q("t6_pulse_fld", p_fld, exp_q);
    exp_q = '{0, 0, 0, 0};
    check_q("t6_pulse_up", p_up, exp_q);
    exp_q = '{10, 21, 30, 41};
    check_q("t6_tick", t_cyc, exp_q);
    check("t6_viol", viol, 0);
    rstn = 1'b0;
    #1;
    check("t6_async_rst", {tick_o, adj_field_o, adj_up_o, adj_dn_o, busy_o}, 0);
    do_reset("t6b");
    steps(12);
    check("t6_idle_after_rst", busy_cnt, 0);
    check("t6_no_pulse_after_rst", p_cyc.size(), 0);
    exp_q = '{10};
    check_q("t6_tick_after_rst", t_cyc, exp_q);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
